// File: rtl/drum_pkg.sv
// Shared definitions for the DRUM approximate arithmetic blocks: default
// operand geometry, derived widths and the sequential divider state encoding.
package drum_pkg;

  localparam int K_DEF    = 6;
  localparam int N_DEF    = 8;
  localparam int M_DEF    = 8;
  localparam int NW_DEF   = $clog2(N_DEF);
  localparam int MW_DEF   = $clog2(M_DEF);
  localparam int K2_DEF   = 2 * K_DEF;
  localparam int MAGW_DEF = 2 * K_DEF + N_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NORM,
    ST_DIV,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/drum_norm.sv
// Leading-one detect and DRUM truncation of an unsigned magnitude: keeps K bits
// from the leading one with the LSB forced to 1, and reports the dropped shift.
module drum_norm #(
  parameter int K = 6,
  parameter int W = 8
) (
  input  logic [W-1:0]         x,
  output logic [K-1:0]         xt,
  output logic [$clog2(W)-1:0] sx
);

  localparam int SW = $clog2(W);

  int lead;

  always_comb begin
    lead = 0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) lead = i;
    end
    xt = x[K-1:0];
    sx = '0;
    if (lead > K - 1) begin
      // Forcing the LSB to 1 centres the truncation error of the dropped bits.
      xt = K'(x >> (lead - K + 1)) | K'(1);
      sx = SW'(lead - K + 1);
    end
  end

endmodule

// File: rtl/drum_div_seq.sv
// Sequential DRUM approximate divider: truncate both magnitudes, restoring
// division one quotient bit per cycle, then rescale, saturate and re-sign.
module drum_div_seq
  import drum_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic         div_zero
);

  localparam int AW   = $clog2(N);
  localparam int BW   = $clog2(M);
  localparam int K2   = 2 * K;
  localparam int MAGW = 2 * K + N;
  localparam int CW   = $clog2(K2) + 1;
  localparam int EW   = $clog2(N + M + K) + 2;
  localparam logic [MAGW-1:0] MAG_MAX = MAGW'((1 << (N - 1)) - 1);

  function automatic logic [N-1:0] sat_mag(input logic [MAGW-1:0] m);
    if (m > MAG_MAX) return MAG_MAX[N-1:0];
    return m[N-1:0];
  endfunction

  state_t state, state_nxt;

  logic [N-1:0]  a_mag_p0;
  logic [M-1:0]  b_mag_p0;
  logic          sign_p0;
  logic [K-1:0]  at_n, bt_n;
  logic [AW-1:0] sa_n;
  logic [BW-1:0] sb_n;
  logic [K-1:0]  bt_p1;
  logic [AW-1:0] sa_p1;
  logic [BW-1:0] sb_p1;
  logic          dz_p1;
  logic [K2-1:0] qd_p2;
  logic [K:0]    rem_p2;
  logic [CW-1:0] cnt_p2;

  logic [K+1:0]       rem_sh, rem_diff;
  logic               qbit;
  logic [K:0]         rem_nxt;
  logic signed [EW-1:0] e_s;
  logic [MAGW-1:0]    qext, mag;
  logic [N-1:0]       mag_fin, q_nxt;

  drum_norm #(.K(K), .W(N)) u_norm_a (.x(a_mag_p0), .xt(at_n), .sx(sa_n));
  drum_norm #(.K(K), .W(M)) u_norm_b (.x(b_mag_p0), .xt(bt_n), .sx(sb_n));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_NORM;
      end
      ST_NORM:  state_nxt = (bt_n == '0) ? ST_SHIFT : ST_DIV;
      ST_DIV:   if (cnt_p2 == CW'(K2 - 1)) state_nxt = ST_SHIFT;
      ST_SHIFT: state_nxt = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt_p2 <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_NORM)     cnt_p2 <= '0;
      else if (state == ST_DIV) cnt_p2 <= cnt_p2 + 1'b1;
    end
  end

  // Restoring step: the borrow out of the trial subtraction decides the bit.
  always_comb begin
    rem_sh   = {rem_p2, qd_p2[K2-1]};
    rem_diff = rem_sh - {2'b00, bt_p1};
    qbit     = ~rem_diff[K+1];
    rem_nxt  = qbit ? rem_diff[K:0] : rem_sh[K:0];
  end

  // Stage p0: accept and fold ones'-complement signs into magnitudes
  // Stage p1: latch truncated operands; Stage p2: iterate the divider
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      a_mag_p0 <= a[N-1] ? ~a : a;
      b_mag_p0 <= b[M-1] ? ~b : b;
      sign_p0  <= a[N-1] ^ b[M-1];
    end
    if (state == ST_NORM) begin
      bt_p1  <= bt_n;
      sa_p1  <= sa_n;
      sb_p1  <= sb_n;
      dz_p1  <= (bt_n == '0);
      qd_p2  <= {at_n, {K{1'b0}}};
      rem_p2 <= '0;
    end else if (state == ST_DIV) begin
      qd_p2  <= {qd_p2[K2-2:0], qbit};
      rem_p2 <= rem_nxt;
    end
  end

  // Output stage: rescale by the truncation shifts minus the K pre-shift
  always_comb begin
    e_s  = EW'(sa_p1) - EW'(sb_p1) - EW'(K);
    qext = MAGW'(qd_p2);
    if (e_s[EW-1]) mag = qext >> (-e_s);
    else           mag = qext << e_s;
    mag_fin = dz_p1 ? MAG_MAX[N-1:0] : sat_mag(mag);
    q_nxt   = sign_p0 ? ~mag_fin : mag_fin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      div_zero <= 1'b0;
    end else if (state == ST_SHIFT) begin
      q        <= q_nxt;
      div_zero <= dz_p1;
    end
  end

endmodule
